// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap to HALT and set the sticky illegal flag.
module multicycle_control #(
    parameter logic [3:0] ALU_AND = 4'b0000,
    parameter logic [3:0] ALU_OR  = 4'b0001,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_PC_INC    = 4'd10,
        S_HALT      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t cur_state, nxt_state;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = S_MEM_ADDR;
                    OP_RTYPE:          nxt_state = S_EXEC_R;
                    OP_ITYPE:          nxt_state = S_EXEC_I;
                    OP_BRANCH:         nxt_state = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:           nxt_state = S_HALT;
`else
                    default:           nxt_state = S_PC_INC;
`endif
                endcase
            end
            S_MEM_ADDR:  nxt_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nxt_state = S_LW_WB;
            S_LW_WB:     nxt_state = S_FETCH;
            S_MEM_WRITE: nxt_state = S_FETCH;
            S_EXEC_R:    nxt_state = S_ALU_WB;
            S_EXEC_I:    nxt_state = S_ALU_WB;
            S_ALU_WB:    nxt_state = S_FETCH;
            S_BRANCH:    nxt_state = zero ? S_FETCH : S_PC_INC;
            S_PC_INC:    nxt_state = S_FETCH;
            S_HALT:      nxt_state = S_HALT;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Reset gates every output so nothing writes during the reset cycle itself.
    always_comb begin
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_AND;
        pc_source   = 1'b0;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                S_MEM_READ: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_LW_WB: begin
                    mem_to_reg  = 1'b1;
                    reg_write   = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    pc_write    = 1'b1;
                end
                S_MEM_WRITE: begin
                    iord        = 1'b1;
                    mem_write   = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    pc_write    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    case ({funct7_5, funct3})
                        4'b1000: alu_control = ALU_SUB;
                        4'b0111: alu_control = ALU_AND;
                        4'b0110: alu_control = ALU_OR;
                        default: alu_control = ALU_ADD;
                    endcase
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (funct3)
                        3'b110:  alu_control = ALU_OR;
                        3'b111:  alu_control = ALU_AND;
                        default: alu_control = ALU_ADD;
                    endcase
                end
                S_ALU_WB, S_PC_INC: begin
                    reg_write   = (cur_state == S_ALU_WB);
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    pc_write    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_source   = 1'b1;
                    pc_write    = zero;
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? 4'd0 : cur_state;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)                     illegal_q <= 1'b0;
        else if (nxt_state == S_HALT)  illegal_q <= 1'b1;
    end

    assign illegal = illegal_q & ~reset;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control; expected state/control vectors are hand-derived constants.
// Follows ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic       alu_src_a, pc_source, illegal;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control, state;
    logic [14:0] ctrl;

    int total = 0;
    int bad   = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_source(pc_source),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_write,iord,mem_read,mem_write,ir_write,mem_to_reg,reg_write,src_a,src_b[1:0],alu[3:0],pc_source}
    assign ctrl = {pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_control, pc_source};

    localparam logic [14:0] C_ZERO    = 15'b0_0_0_0_0_0_0_0_00_0000_0;
    localparam logic [14:0] C_FETCH   = 15'b0_0_1_0_1_0_0_0_00_0000_0;
    localparam logic [14:0] C_DECODE  = 15'b0_0_0_0_0_0_0_0_10_0010_0;
    localparam logic [14:0] C_AIMM    = 15'b0_0_0_0_0_0_0_1_10_0010_0;
    localparam logic [14:0] C_AIMM_OR = 15'b0_0_0_0_0_0_0_1_10_0001_0;
    localparam logic [14:0] C_ALU_WB  = 15'b1_0_0_0_0_0_1_0_01_0010_0;
    localparam logic [14:0] C_MEM_RD  = 15'b0_1_1_0_0_0_0_0_00_0000_0;
    localparam logic [14:0] C_LW_WB   = 15'b1_0_0_0_0_1_1_0_01_0010_0;
    localparam logic [14:0] C_MEM_WR  = 15'b1_1_0_1_0_0_0_0_01_0010_0;
    localparam logic [14:0] C_R_SUB   = 15'b0_0_0_0_0_0_0_1_00_0110_0;
    localparam logic [14:0] C_R_AND   = 15'b0_0_0_0_0_0_0_1_00_0000_0;
    localparam logic [14:0] C_R_OR    = 15'b0_0_0_0_0_0_0_1_00_0001_0;
    localparam logic [14:0] C_R_ADD   = 15'b0_0_0_0_0_0_0_1_00_0010_0;
    localparam logic [14:0] C_BR_T    = 15'b1_0_0_0_0_0_0_1_00_0110_1;
    localparam logic [14:0] C_BR_NT   = 15'b0_0_0_0_0_0_0_1_00_0110_1;
    localparam logic [14:0] C_PC_INC  = 15'b1_0_0_0_0_0_0_0_01_0010_0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f75, input logic z);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
        zero     = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkNow(input string tag, input logic [3:0] es, input logic [14:0] ec);
        checkOutput({tag, ".state"}, {28'd0, state}, {28'd0, es});
        checkOutput({tag, ".ctrl"}, {17'd0, ctrl}, {17'd0, ec});
    endtask

    task automatic stepCheck(input string tag, input logic [3:0] es, input logic [14:0] ec);
        tick();
        checkNow(tag, es, ec);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(7'd0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkNow("rst", 4'd0, C_ZERO);
        checkOutput("rst.illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        #1;

        // addi x3,x0,20 : 0x01400193
        applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b0);
        checkNow("addi.fetch", 4'd0, C_FETCH);
        stepCheck("addi.decode", 4'd1, C_DECODE);
        stepCheck("addi.exec", 4'd7, C_AIMM);
        stepCheck("addi.wb", 4'd8, C_ALU_WB);
        stepCheck("addi.next", 4'd0, C_FETCH);

        // lw x8,120(x3) : 0x0781A403
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
        stepCheck("lw.decode", 4'd1, C_DECODE);
        stepCheck("lw.addr", 4'd2, C_AIMM);
        stepCheck("lw.read", 4'd3, C_MEM_RD);
        stepCheck("lw.wb", 4'd4, C_LW_WB);
        stepCheck("lw.next", 4'd0, C_FETCH);

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        stepCheck("sw.decode", 4'd1, C_DECODE);
        stepCheck("sw.addr", 4'd2, C_AIMM);
        stepCheck("sw.write", 4'd5, C_MEM_WR);
        stepCheck("sw.next", 4'd0, C_FETCH);

        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
        stepCheck("sub.decode", 4'd1, C_DECODE);
        stepCheck("sub.exec", 4'd6, C_R_SUB);
        stepCheck("sub.wb", 4'd8, C_ALU_WB);
        stepCheck("sub.next", 4'd0, C_FETCH);

        // Same EXEC_R state, varying funct fields combinationally
        applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0);
        stepCheck("and.decode", 4'd1, C_DECODE);
        stepCheck("and.exec", 4'd6, C_R_AND);
        applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0);
        #1 checkNow("or.exec", 4'd6, C_R_OR);
        applyStimulus(7'b0110011, 3'b111, 1'b1, 1'b0);
        #1 checkNow("r.dflt", 4'd6, C_R_ADD);
        stepCheck("and.wb", 4'd8, C_ALU_WB);
        stepCheck("and.next", 4'd0, C_FETCH);

        applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0);
        stepCheck("ori.decode", 4'd1, C_DECODE);
        stepCheck("ori.exec", 4'd7, C_AIMM_OR);
        applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0);
        #1 checkNow("slti.exec", 4'd7, C_AIMM);
        stepCheck("ori.wb", 4'd8, C_ALU_WB);
        stepCheck("ori.next", 4'd0, C_FETCH);

        // beq taken; funct3=001 is still treated as beq
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1);
        stepCheck("beqt.decode", 4'd1, C_DECODE);
        stepCheck("beqt.branch", 4'd9, C_BR_T);
        stepCheck("beqt.next", 4'd0, C_FETCH);

        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
        stepCheck("beqn.decode", 4'd1, C_DECODE);
        stepCheck("beqn.branch", 4'd9, C_BR_NT);
        stepCheck("beqn.pcinc", 4'd10, C_PC_INC);
        stepCheck("beqn.next", 4'd0, C_FETCH);

        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
        stepCheck("ill.decode", 4'd1, C_DECODE);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            stepCheck("ill.halt", 4'd11, C_ZERO);
            checkOutput("ill.flag", {31'd0, illegal}, 32'd1);
        end
        reset = 1'b1;
        #1 checkOutput("ill.rstflag", {31'd0, illegal}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkNow("ill.clear", 4'd0, C_FETCH);
        checkOutput("ill.cleared", {31'd0, illegal}, 32'd0);
`else
        stepCheck("ill.pcinc", 4'd10, C_PC_INC);
        checkOutput("ill.flag", {31'd0, illegal}, 32'd0);
        stepCheck("ill.next", 4'd0, C_FETCH);
        checkOutput("ill.flag2", {31'd0, illegal}, 32'd0);
`endif

        // Reset arriving in MEM_WRITE must kill the store in that same cycle
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        stepCheck("swr.decode", 4'd1, C_DECODE);
        stepCheck("swr.addr", 4'd2, C_AIMM);
        stepCheck("swr.write", 4'd5, C_MEM_WR);
        reset = 1'b1;
        #1 checkNow("swr.reset", 4'd0, C_ZERO);
        checkOutput("swr.mem_write", {31'd0, mem_write}, 32'd0);
        tick();
        reset = 1'b0;
        #1 checkNow("swr.refetch", 4'd0, C_FETCH);
        stepCheck("swr.decode2", 4'd1, C_DECODE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Decodes opcode/funct fields from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives every mux select, write enable and the 4-bit ALU control code consumed by the datapath.
- Also owns PC update policy:
  - PC holds the address of the current instruction until that instruction's final state.
  - The branch target is computed in DECODE as PC+imm.

Parameters:
- ALU_AND, 4'b0000, ALU code for AND
- ALU_OR, 4'b0001, ALU code for OR
- ALU_ADD, 4'b0010, ALU code for add
- ALU_SUB, 4'b0110, ALU code for subtract

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- ir_write  out  1  IR enable
- mem_to_reg  out  1  register-file write data select: 0=ALUOut, 1=MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=imm
- alu_control  out  4  ALU operation code
- pc_source  out  1  0=ALU result, 1=ALUOut
- state  out  4  current state encoding (debug)
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset:
  - State reg <= FETCH; illegal <= 0.
  - While reset is high, all outputs are forced 0, including mem_read and alu_control=ALU_AND.
  - First FETCH occurs in the cycle after reset deasserts.
  - Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Outputs are combinational from state; pc_write in BRANCH also depends on zero. Unlisted outputs are 0 in every state.
- "PC+4" below means: alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_source=0, pc_write=1.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, LW_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, PC_INC=10, HALT=11.
- States and transitions:
  - FETCH: iord=0, mem_read=1, ir_write=1 -> DECODE.
  - DECODE: alu_src_a=0, alu_src_b=10, ADD (ALUOut <= branch target). Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - other -> illegal handling (see Optional Feature)
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_READ if opcode=0000011, else MEM_WRITE.
  - MEM_READ: iord=1, mem_read=1 -> LW_WB.
  - LW_WB: mem_to_reg=1, reg_write=1, plus PC+4 -> FETCH.
  - MEM_WRITE: iord=1, mem_write=1, plus PC+4 -> FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00. ALU code from {funct7_5,funct3}:
    - 0000 -> ADD, 1000 -> SUB, 0111 -> AND, 0110 -> OR; others -> ADD.
    - Next -> ALU_WB.
  - EXEC_I: alu_src_a=1, alu_src_b=10. ALU code from funct3:
    - 000 -> ADD, 110 -> OR, 111 -> AND; others -> ADD.
    - Next -> ALU_WB.
  - ALU_WB: mem_to_reg=0, reg_write=1, plus PC+4 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=1, pc_write=zero.
    - zero=1 -> FETCH (PC <= ALUOut target).
    - zero=0 -> PC_INC.
  - PC_INC: PC+4 -> FETCH.
  - HALT: all outputs 0; stays until reset.
- CPI: lw 5, sw 4, R-type 4, I-type ALU 4, beq taken 3, beq not taken 4.
- Never asserted together: mem_read with mem_write; ir_write outside FETCH; reg_write outside LW_WB/ALU_WB.
- Branch funct3 is ignored: all opcode 1100011 instructions behave as beq.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE -> HALT; illegal <= 1 on entering HALT and holds until reset.
- Undefined: an unrecognised opcode in DECODE -> PC_INC, executing as a NOP; illegal is tied to 0 and HALT is unreachable.

Test Plan:
- Reset held 2 cycles, then IR=0x01400193 (addi x3,x0,20) -> states 0,1,7,8,0. In EXEC_I: alu_src_b=10, alu_control=0010. In ALU_WB: reg_write=1, pc_write=1, pc_source=0.
- IR=0x0781A403 (lw x8,120(x3)) -> states 0,1,2,3,4,0. MEM_READ: iord=1, mem_read=1. LW_WB: mem_to_reg=1, reg_write=1, pc_write=1.
- sw opcode 0100011 -> states 0,1,2,5,0. In MEM_WRITE: mem_write=1, mem_read=0, reg_write=0.
- R-type sub (funct7_5=1, funct3=000) -> alu_control=0110 in EXEC_R. With funct3=111 and funct7_5=0 -> 0000.
- beq with zero=1 in BRANCH -> pc_write=1, pc_source=1, next FETCH (3 cycles). With zero=0 -> pc_write=0, next PC_INC, then pc_write=1, pc_source=0.
- opcode 1111111: with ILLEGAL_TRAP_EN -> state 11, illegal=1, all enables 0 for 10 cycles, cleared by reset. Without the macro -> PC_INC then FETCH, illegal=0.
- Reset asserted during MEM_WRITE -> mem_write=0 in that cycle; next state FETCH.
